// File: rtl/keccak_pad_absorb.sv
// ----------------------------------------------------------------------------
// keccak_pad_absorb
//
// Splits a message into rate-sized blocks of 64-bit lanes, applies Keccak
// pad10*1 with a configurable domain-separation byte, and writes every lane
// to the state datapath (which XORs it in). After each full block it starts
// the permutation and waits for it to finish.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              one-cycle pulse, begins a new message (IDLE only)
//   msg_valid_i/ready_o  message lane handshake
//   msg_data_i           message lane, little-endian bytes
//   msg_last_i           final lane of the message
//   msg_bytes_i          valid bytes in the final lane (0..8)
//   lane_we_o            lane write strobe to the state datapath
//   lane_idx_o           lane index within the rate block
//   lane_data_o          lane value, padded where applicable
//   perm_ready_i         permutation controller idle
//   perm_start_o         one-cycle permutation start pulse
//   perm_done_i          one-cycle permutation-complete pulse
//   busy_o               high whenever the FSM is not IDLE
//   absorb_done_o        one-cycle pulse once the last block is permuted
//   dbg_state_o          current FSM state, for observation only
//
// Handshake: a lane is transferred on a rising edge where msg_valid_i and
// msg_ready_o are both high. msg_ready_o depends only on the FSM state, never
// on msg_valid_i. The transferred lane appears on lane_data_o/lane_idx_o
// with lane_we_o high in the following cycle.
// ----------------------------------------------------------------------------
module keccak_pad_absorb #(
    parameter int          RATE_LANES = 17,
    parameter logic [7:0]  DSBYTE     = 8'h06
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [63:0] msg_data_i,
    input  logic        msg_last_i,
    input  logic [3:0]  msg_bytes_i,
    output logic        lane_we_o,
    output logic [4:0]  lane_idx_o,
    output logic [63:0] lane_data_o,
    input  logic        perm_ready_i,
    output logic        perm_start_o,
    input  logic        perm_done_i,
    output logic        busy_o,
    output logic        absorb_done_o,
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABSORB = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [4:0]  LAST_IDX = 5'(RATE_LANES - 1);
    localparam logic [63:0] PAD_END  = 64'h8000_0000_0000_0000;

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    // final_q: the block being built ends the padding (next permutation is the last).
    // pend_q : the message ended on a full lane, DSBYTE still has to be emitted.
    logic        final_q, final_d;
    logic        pend_q, pend_d;
    logic        lane_we_q, lane_we_d;
    logic [4:0]  lane_idx_q, lane_idx_d;
    logic [63:0] lane_data_q, lane_data_d;

    logic        tail_short;
    logic [5:0]  byte_shift;
    logic [63:0] keep_mask;
    logic [63:0] absorb_lane;
    logic [63:0] pad_lane;
    logic        start_fire;

    // Padded form of the incoming lane. A short final lane keeps bytes
    // 0..n-1, gets DSBYTE in byte n and zeros above it. msg_bytes_i values
    // of 8 or more are treated as a full lane.
    always_comb begin
        tail_short  = msg_last_i && (msg_bytes_i < 4'd8);
        byte_shift  = {msg_bytes_i[2:0], 3'b000};
        keep_mask   = ~({64{1'b1}} << byte_shift);
        absorb_lane = msg_data_i;
        if (tail_short) begin
            absorb_lane = (msg_data_i & keep_mask) | ({56'd0, DSBYTE} << byte_shift);
            if (idx_q == LAST_IDX) begin
                absorb_lane = absorb_lane | PAD_END;
            end
        end
    end

    // Fill lane: DSBYTE only if a full final lane left it pending, and the
    // closing 0x80 on the last lane of the block (both may share one lane).
    always_comb begin
        pad_lane = 64'd0;
        if (pend_q) begin
            pad_lane[7:0] = DSBYTE;
        end
        if (idx_q == LAST_IDX) begin
            pad_lane = pad_lane | PAD_END;
        end
    end

    // The block's last lane write lands in the first START cycle; holding the
    // start pulse off while lane_we_q is high keeps the two apart.
    assign start_fire = (state_q == S_START) && perm_ready_i && !lane_we_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        final_d     = final_q;
        pend_d      = pend_q;
        lane_we_d   = 1'b0;
        lane_idx_d  = lane_idx_q;
        lane_data_d = lane_data_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ABSORB;
                    idx_d   = 5'd0;
                    final_d = 1'b0;
                    pend_d  = 1'b0;
                end
            end

            S_ABSORB: begin
                if (msg_valid_i) begin
                    lane_we_d   = 1'b1;
                    lane_idx_d  = idx_q;
                    lane_data_d = absorb_lane;
                    if (msg_last_i) begin
                        if (tail_short) begin
                            final_d = 1'b1;
                        end else begin
                            pend_d  = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 5'd0;
                        state_d = S_START;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = msg_last_i ? S_PAD : S_ABSORB;
                    end
                end
            end

            S_PAD: begin
                lane_we_d   = 1'b1;
                lane_idx_d  = idx_q;
                lane_data_d = pad_lane;
                pend_d      = 1'b0;
                final_d     = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 5'd0;
                    state_d = S_START;
                end else begin
                    idx_d   = idx_q + 5'd1;
                end
            end

            S_START: begin
                if (start_fire) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (perm_done_i) begin
                    if (final_q) begin
                        state_d = S_DONE;
                    end else if (pend_q) begin
                        // Full final lane filled the block: one extra block.
                        state_d = S_PAD;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            final_q     <= 1'b0;
            pend_q      <= 1'b0;
            lane_we_q   <= 1'b0;
            lane_idx_q  <= 5'd0;
            lane_data_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            final_q     <= final_d;
            pend_q      <= pend_d;
            lane_we_q   <= lane_we_d;
            lane_idx_q  <= lane_idx_d;
            lane_data_q <= lane_data_d;
        end
    end

    assign msg_ready_o   = (state_q == S_ABSORB);
    assign lane_we_o     = lane_we_q;
    assign lane_idx_o    = lane_idx_q;
    assign lane_data_o   = lane_data_q;
    assign perm_start_o  = start_fire;
    assign busy_o        = (state_q != S_IDLE);
    assign absorb_done_o = (state_q == S_DONE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_keccak_pad_absorb.sv
// ----------------------------------------------------------------------------
// tb_keccak_pad_absorb
//
// Bench for keccak_pad_absorb (RATE_LANES=17, DSBYTE=8'h06). Expected lanes
// come from a byte-level pad10*1 model: message bytes, then DSBYTE, zeros up
// to a whole number of rate blocks, 0x80 ORed into the very last byte.
// A small responder plays the permutation controller.
// ----------------------------------------------------------------------------
module tb_keccak_pad_absorb;

    localparam int         RL = 17;
    localparam logic [7:0] DS = 8'h06;
    localparam int         RB = RL * 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [63:0] msg_data_i;
    logic        msg_last_i;
    logic [3:0]  msg_bytes_i;
    logic        lane_we_o;
    logic [4:0]  lane_idx_o;
    logic [63:0] lane_data_o;
    logic        perm_ready_i;
    logic        perm_start_o;
    logic        perm_done_i;
    logic        busy_o;
    logic        absorb_done_o;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    keccak_pad_absorb #(
        .RATE_LANES (RL),
        .DSBYTE     (DS)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .msg_valid_i   (msg_valid_i),
        .msg_ready_o   (msg_ready_o),
        .msg_data_i    (msg_data_i),
        .msg_last_i    (msg_last_i),
        .msg_bytes_i   (msg_bytes_i),
        .lane_we_o     (lane_we_o),
        .lane_idx_o    (lane_idx_o),
        .lane_data_o   (lane_data_o),
        .perm_ready_i  (perm_ready_i),
        .perm_start_o  (perm_start_o),
        .perm_done_i   (perm_done_i),
        .busy_o        (busy_o),
        .absorb_done_o (absorb_done_o),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [4:0]  exp_idx_q[$];
    logic [63:0] msg_q[$];
    int          perm_cnt = 0;
    int          done_cnt = 0;
    bit          mon_en   = 1'b0;
    bit          noise_en = 1'b0;
    logic [63:0] mon_exp;
    logic [4:0]  mon_exp_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: byte-level pad10*1 over msg_q, appended to exp_q.
    task automatic model_msg(input int last_bytes, output int n_blocks);
        logic [7:0]  b[$];
        logic [63:0] lane;
        int          nl;
        nl = msg_q.size();
        for (int i = 0; i < nl; i++) begin
            lane = msg_q[i];
            for (int k = 0; k < 8; k++) begin
                if (i < nl - 1 || k < last_bytes) b.push_back(lane[8*k +: 8]);
            end
        end
        b.push_back(DS);
        while (b.size() % RB != 0) b.push_back(8'h00);
        b[b.size() - 1] = b[b.size() - 1] | 8'h80;
        n_blocks = b.size() / RB;
        for (int j = 0; j < b.size() / 8; j++) begin
            lane = 64'd0;
            for (int k = 0; k < 8; k++) lane[8*k +: 8] = b[8*j + k];
            exp_q.push_back(lane);
            exp_idx_q.push_back(5'(j % RL));
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && rst_ni) begin
            if (lane_we_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_lane", 64'd1, 64'd0);
                end else begin
                    mon_exp     = exp_q.pop_front();
                    mon_exp_idx = exp_idx_q.pop_front();
                    check("lane_data", lane_data_o, mon_exp);
                    check("lane_idx", 64'(lane_idx_o), 64'(mon_exp_idx));
                end
            end
            if (perm_start_o) begin
                perm_cnt++;
                check("start_with_we", 64'(lane_we_o), 64'd0);
                check("start_ready", 64'(perm_ready_i), 64'd1);
            end
            if (absorb_done_o) done_cnt++;
        end
    end

    // ---------------- permutation responder ----------------
    // Answers each start with a done pulse after 1..4 cycles. When the DUT
    // is idle or absorbing, it may also throw in a stray done pulse, which
    // must be ignored.
    initial begin
        perm_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (perm_start_o) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 perm_done_i = 1'b1;
                @(posedge clk);
                #1 perm_done_i = 1'b0;
            end else if (noise_en && (!busy_o || msg_ready_o) && $urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1 perm_done_i = 1'b1;
                @(posedge clk);
                #1 perm_done_i = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_lane(input logic [63:0] data, input bit last, input logic [3:0] nbytes, output bit ok);
        int t;
        bit rdy;
        repeat ($urandom_range(0, 2)) begin
            msg_valid_i = 1'b0;
            msg_data_i  = rnd64();
            @(posedge clk); #1;
        end
        msg_valid_i = 1'b1;
        msg_data_i  = data;
        msg_last_i  = last;
        msg_bytes_i = nbytes;
        t   = 0;
        rdy = 1'b0;
        while (!rdy && t < 200) begin
            @(negedge clk);
            rdy = msg_ready_o;
            @(posedge clk); #1;
            t++;
        end
        ok = rdy;
        if (!rdy) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_msg(input int last_bytes, input bit stall);
        int n_blocks, base_perm, base_done, nl, t;
        bit ok;
        model_msg(last_bytes, n_blocks);
        base_perm = perm_cnt;
        base_done = done_cnt;
        nl        = msg_q.size();
        if (stall) perm_ready_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < nl && ok; i++) begin
            send_lane(msg_q[i], (i == nl - 1),
                      (i == nl - 1) ? 4'(last_bytes) : 4'($urandom_range(0, 15)), ok);
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        if (stall) begin
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            repeat (5) @(posedge clk);
            #1;
            check("stall_no_start", 64'(perm_cnt - base_perm), 64'd0);
            perm_ready_i = 1'b1;
        end
        // Junk on the message port while not absorbing must be ignored.
        t = 0;
        while (done_cnt == base_done && t < 600) begin
            msg_valid_i = 1'($urandom_range(0, 1));
            msg_last_i  = 1'($urandom_range(0, 1));
            msg_bytes_i = 4'($urandom_range(0, 15));
            msg_data_i  = rnd64();
            @(posedge clk); #1;
            t++;
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        if (t >= 600) check("done_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("perm_starts", 64'(perm_cnt - base_perm), 64'(n_blocks));
        check("done_pulses", 64'(done_cnt - base_done), 64'd1);
        check("lanes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        exp_idx_q.delete();
        msg_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 64'(msg_ready_o), 64'd0);
        check({tag, "_we"}, 64'(lane_we_o), 64'd0);
        check({tag, "_idx"}, 64'(lane_idx_o), 64'd0);
        check({tag, "_data"}, lane_data_o, 64'd0);
        check({tag, "_pstart"}, 64'(perm_start_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(absorb_done_o), 64'd0);
    endtask

    // Reset in the middle of a block: everything clears at once and the
    // partial message is dropped.
    task automatic reset_mid_absorb();
        bit ok;
        mon_en  = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) send_lane(rnd64(), 1'b0, 4'd0, ok);
        msg_valid_i = 1'b1;
        msg_data_i  = rnd64();
        rst_ni      = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_wait_ready", 64'(msg_ready_o), 64'd0);
            check("rst_wait_we", 64'(lane_we_o), 64'd0);
        end
        @(posedge clk); #1;
        msg_valid_i = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
        mon_en = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        msg_valid_i  = 1'b0;
        msg_data_i   = 64'd0;
        msg_last_i   = 1'b0;
        msg_bytes_i  = 4'd0;
        perm_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        mon_en   = 1'b1;
        noise_en = 1'b1;

        // Empty message: garbage data with zero valid bytes.
        msg_q.push_back(rnd64());
        run_msg(0, 1'b0);

        // One short lane, three bytes.
        msg_q.push_back(64'h0000_0000_00CC_BBAA);
        run_msg(3, 1'b0);

        // 17 full lanes: padding spills into a second block.
        for (int i = 0; i < RL; i++) msg_q.push_back(rnd64());
        run_msg(8, 1'b0);

        // 16 full lanes plus 7 bytes: DSBYTE and 0x80 share byte 7.
        for (int i = 0; i < RL; i++) msg_q.push_back(rnd64());
        run_msg(7, 1'b0);

        // 16 full lanes: single PAD lane carries both DSBYTE and 0x80.
        for (int i = 0; i < RL - 1; i++) msg_q.push_back(rnd64());
        run_msg(8, 1'b0);

        // Permutation controller busy while the block waits in START.
        msg_q.push_back(rnd64());
        run_msg(0, 1'b1);

        reset_mid_absorb();

        // Clean message right after the reset.
        msg_q.push_back(rnd64());
        msg_q.push_back(rnd64());
        run_msg(5, 1'b0);

        for (int m = 0; m < 15; m++) begin
            int nl;
            nl = $urandom_range(1, 40);
            for (int i = 0; i < nl; i++) msg_q.push_back(rnd64());
            run_msg($urandom_range(0, 8), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        check("watchdog", 64'd0, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keccak_pad_absorb.md
KECCAK_PAD_ABSORB -- requirements
Module: keccak_pad_absorb

Interface
REQ-001 SHALL have parameter RATE_LANES, default 17, number of 64-bit lanes per rate block (legal 2..21).
REQ-002 SHALL have parameter DSBYTE, default 8'h06, domain-separation/first padding byte.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  one-cycle pulse, begins a new message.
REQ-006 msg_valid_i  in  1  message lane valid.
REQ-007 msg_ready_o  out  1  message lane accepted when valid and ready are both high.
REQ-008 msg_data_i  in  64  message lane, little-endian: byte k = bits [8k+7:8k].
REQ-009 msg_last_i  in  1  final lane of the message.
REQ-010 msg_bytes_i  in  4  valid bytes in the final lane, 0..8; ignored unless msg_last_i.
REQ-011 lane_we_o  out  1  lane write strobe to the state datapath, which XORs the lane in.
REQ-012 lane_idx_o  out  5  lane index within the rate block.
REQ-013 lane_data_o  out  64  lane value, padded where applicable.
REQ-014 perm_ready_i  in  1  permutation controller idle.
REQ-015 perm_start_o  out  1  one-cycle permutation start pulse.
REQ-016 perm_done_i  in  1  one-cycle pulse, permutation complete.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 absorb_done_o  out  1  one-cycle pulse, last block permuted.

Function
REQ-019 States SHALL be IDLE, ABSORB, PAD, START, WAIT, DONE.
REQ-020 IDLE->ABSORB on start_i; lane index cleared to 0, final flag and pending-pad flag cleared; in other states start_i is ignored.
REQ-021 msg_ready_o SHALL be high only in ABSORB.
REQ-022 Each accepted lane SHALL appear on lane_data_o/lane_idx_o with lane_we_o high exactly one cycle after acceptance; lane_we_o is low otherwise.
REQ-023 Non-final lanes SHALL pass through unchanged.
REQ-024 Final lane, n = msg_bytes_i < 8: bytes >= n zeroed, byte n = DSBYTE, final flag set.
REQ-025 Final lane, n = 8: passed unchanged, pending-pad flag set; DSBYTE goes in byte 0 of the next emitted lane.
REQ-026 The lane at index RATE_LANES-1 of the final block SHALL have byte 7 ORed with 8'h80; this includes the case where DSBYTE lands on that same byte, giving 8'h86.
REQ-027 After a final lane at index < RATE_LANES-1: ABSORB->PAD.
REQ-028 PAD SHALL emit one lane per cycle up to index RATE_LANES-1, then go to START. Each PAD lane is zero, except that the first PAD lane takes DSBYTE in byte 0 when pending-pad is set.
REQ-029 After lane index RATE_LANES-1 is written, the lane index SHALL wrap to 0 and the FSM SHALL enter START.
REQ-030 Final lane with n = 8 at index RATE_LANES-1: that block is not final. After its permutation the FSM SHALL go to PAD at index 0 and emit one extra block: lane0 = DSBYTE, last lane = 8'h80 in byte 7.
REQ-031 START SHALL hold perm_start_o low until perm_ready_i is high, then pulse it for exactly one cycle, then enter WAIT.
REQ-032 WAIT: on perm_done_i, go to DONE if the final block was just permuted, else to ABSORB (or PAD per REQ-030).
REQ-033 DONE SHALL pulse absorb_done_o for one cycle and return to IDLE.
REQ-034 perm_done_i outside WAIT and msg_valid_i outside ABSORB SHALL be ignored; no lane is lost or duplicated.
REQ-035 perm_start_o SHALL never be asserted in the same cycle as lane_we_o.

Reset
REQ-036 While rst_ni is low: state = IDLE, lane index = 0, flags cleared, all outputs 0, including mid-block.
REQ-037 After reset release the block SHALL wait for start_i; a partially absorbed message is discarded.

Verification (RATE_LANES=17, DSBYTE=8'h06)
REQ-038 Empty message (msg_last_i=1, msg_bytes_i=0) -> lane0=64'h06, lanes1..15=0, lane16=64'h8000000000000000, one perm_start_o, absorb_done_o after perm_done_i.
REQ-039 One lane 64'h0000000000CCBBAA, bytes=3 -> lane0=64'h0000000006CCBBAA, 16 PAD lanes, lane16 top byte 8'h80.
REQ-040 17 full lanes, last at lane16 with bytes=8 -> first block unchanged; second block lane0=64'h06, lane16=64'h8000000000000000; two perm_start_o pulses, one absorb_done_o.
REQ-041 16 full lanes plus lane16 with bytes=7 -> lane16 byte7 = 8'h86, no extra block.
REQ-042 Hold perm_ready_i low for 5 cycles in START -> no perm_start_o until it rises, then exactly one pulse; assert rst_ni low mid-ABSORB -> all outputs 0 immediately, IDLE, msg_ready_o low.
